// File: rtl/mem_access_controller.sv
// Sequences pipeline loads/stores onto a multi-cycle req/ack data bus, freezing the
// pipeline until each access completes (ack) or is abandoned after TIMEOUT cycles.
module mem_access_controller #(
    parameter logic [31:0] ADDR_BASE = 32'd1024,
    parameter int unsigned WORD_AW   = 16,
    parameter int unsigned TIMEOUT   = 15
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_mem_r_en,
    input  logic               i_mem_w_en,
    input  logic [31:0]        i_addr,
    input  logic [31:0]        i_st_val,
    output logic               o_freeze,
    output logic [31:0]        o_rdata,
    output logic               o_rdata_valid,
    output logic               o_err,
    output logic               o_bus_req,
    output logic               o_bus_we,
    output logic [WORD_AW-1:0] o_bus_addr,
    output logic [31:0]        o_bus_wdata,
    input  logic [31:0]        i_bus_rdata,
    input  logic               i_bus_ack
);

    typedef enum logic [1:0] {StIdle, StAccess, StDone} state_t;

    state_t             r_state, w_state_nxt;
    logic               r_bus_req, w_bus_req_nxt;
    logic               r_bus_we, w_bus_we_nxt;
    logic [WORD_AW-1:0] r_bus_addr, w_bus_addr_nxt;
    logic [31:0]        r_bus_wdata, w_bus_wdata_nxt;
    logic [31:0]        r_rdata, w_rdata_nxt;
    logic               r_rdata_valid, w_rdata_valid_nxt;
    logic               r_err, w_err_nxt;
    logic [7:0]         r_cnt, w_cnt_nxt;

    logic               w_req;
    logic [31:0]        w_addr_off;

    assign w_req      = i_mem_r_en | i_mem_w_en;
    assign w_addr_off = i_addr - ADDR_BASE;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_bus_req     <= 1'b0;
            r_bus_we      <= 1'b0;
            r_bus_addr    <= '0;
            r_bus_wdata   <= '0;
            r_rdata       <= '0;
            r_rdata_valid <= 1'b0;
            r_err         <= 1'b0;
            r_cnt         <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_bus_req     <= w_bus_req_nxt;
            r_bus_we      <= w_bus_we_nxt;
            r_bus_addr    <= w_bus_addr_nxt;
            r_bus_wdata   <= w_bus_wdata_nxt;
            r_rdata       <= w_rdata_nxt;
            r_rdata_valid <= w_rdata_valid_nxt;
            r_err         <= w_err_nxt;
            r_cnt         <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt       = r_state;
        w_bus_req_nxt     = r_bus_req;
        w_bus_we_nxt      = r_bus_we;
        w_bus_addr_nxt    = r_bus_addr;
        w_bus_wdata_nxt   = r_bus_wdata;
        w_rdata_nxt       = r_rdata;
        w_rdata_valid_nxt = 1'b0;
        w_err_nxt         = 1'b0;
        w_cnt_nxt         = r_cnt;
        unique case (r_state)
            StIdle: begin
                if (w_req) begin
                    // A simultaneous read+write request is issued as a write only.
                    w_state_nxt     = StAccess;
                    w_bus_req_nxt   = 1'b1;
                    w_bus_we_nxt    = i_mem_w_en;
                    w_bus_addr_nxt  = WORD_AW'(w_addr_off >> 2);
                    w_bus_wdata_nxt = i_st_val;
                    w_cnt_nxt       = '0;
                end
            end
            StAccess: begin
                if (i_bus_ack) begin
                    if (!r_bus_we) begin
                        w_rdata_nxt       = i_bus_rdata;
                        w_rdata_valid_nxt = 1'b1;
                    end
                    w_bus_req_nxt = 1'b0;
                    w_state_nxt   = StDone;
                end else if (r_cnt == 8'(TIMEOUT - 1)) begin
                    w_bus_req_nxt = 1'b0;
                    w_err_nxt     = 1'b1;
                    w_state_nxt   = StDone;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
            end
            StDone: w_state_nxt = StIdle;
            default: w_state_nxt = StIdle;
        endcase
    end

    // Freeze in IDLE too, so the pipe never advances past a not-yet-issued access.
    assign o_freeze      = !i_rst && ((r_state == StIdle && w_req) || r_state == StAccess);
    assign o_rdata       = r_rdata;
    assign o_rdata_valid = r_rdata_valid;
    assign o_err         = r_err;
    assign o_bus_req     = r_bus_req;
    assign o_bus_we      = r_bus_we;
    assign o_bus_addr    = r_bus_addr;
    assign o_bus_wdata   = r_bus_wdata;

endmodule
